input_event_capture: RTL
========================

Name: input_event_capture

Overview:
- Parametrised successor to the fixed six-player joystick fan-in feeding `system`.
- Samples N player input words once per frame, on the rising edge of vblank.
- Diffs each player's word against the previous frame's snapshot.
- Pushes per-player press/release events, timestamped, into a show-ahead FIFO that the core CPU reads. Button transitions are therefore captured with frame-accurate timing instead of being polled.
- Sits between hps_io joystick outputs and the system bus, in the clk_sys domain.

Parameters:
- PLAYERS, 6, number of input channels; range 1..8.
- JOY_W, 32, bits per player input word.
- DEPTH, 16, event FIFO entries; power of two, ≥2.
- TS_W, 33, timestamp width.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- joystick  in  PLAYERS*JOY_W  packed player words; player 0 in the LSBs.
- timestamp  in  TS_W  free-running time value from hps_io.
- vblank  in  1  vertical blank, active high.
- enable  in  1  when 0, frame edges are ignored.
- clear  in  1  synchronous flush pulse.
- rd_en  in  1  pop head event.
- rd_valid  out  1  FIFO non-empty.
- rd_player  out  3  head event player index.
- rd_pressed  out  JOY_W  bits that went 0→1.
- rd_released  out  JOY_W  bits that went 1→0.
- rd_timestamp  out  TS_W  timestamp latched at the frame edge.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.
- overflow  out  1  sticky; set when an event is dropped.
- snapshot  out  PLAYERS*JOY_W  last frame-latched input words.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, FSM in IDLE, previous-snapshot registers 0.
  - Buttons held at the first frame after reset therefore produce press events. This is intended.
- Input registration:
  - joystick, timestamp and vblank are registered once: joy_q, ts_q, vb_q.
  - vb_q is delayed again into vb_qq.
  - frame_edge = vb_q & ~vb_qq & enable.
- FSM states and transitions:
  - IDLE: on frame_edge, latch cur ← joy_q and ts_lat ← ts_q; idx ← 0; go to SCAN.
  - SCAN, one player per cycle:
    - diff = cur[idx] ^ prev[idx].
    - If diff ≠ 0, push {idx, cur & diff, ~cur & diff, ts_lat}.
    - prev[idx] ← cur[idx].
    - idx increments; after idx = PLAYERS-1, return to IDLE.
  - frame_edge during SCAN is ignored; the snapshot is not relatched.
- snapshot output equals the prev registers.
- Latency: count the clock that samples vblank=1 as clock 0.
  - Clock 1: latch.
  - Clock 2+p: player p's event written.
  - rd_valid rises after clock 2 when player 0 changed and the FIFO was empty.
- FIFO is show-ahead:
  - rd_* present the head entry whenever rd_valid=1; rd_en pops on that clock.
  - rd_en while empty is ignored.
  - Push while full and no pop: event dropped, overflow ← 1; prev is still updated.
  - Push and pop on the same clock while full: both occur, count unchanged, no overflow.
  - Push and pop on the same clock while empty: only the push occurs.
- Pointers are $clog2(DEPTH) bits and wrap naturally; count tracks occupancy exactly (0..DEPTH).
- clear has priority over every other action on that clock:
  - FIFO emptied, overflow ← 0, FSM → IDLE.
  - prev ← joy_q, so no event burst follows.
  - Any rd_en or push on that clock is discarded.
- enable=0 suppresses new frame edges only. A scan in progress completes, and reads continue.

Decomposition:
- Package input_event_capture_pkg holds:
  - state enum {IDLE, SCAN};
  - event struct typedef (player, pressed, released, ts), parameterised via localparams;
  - helper function for the PIDX width.
- Sub-module input_event_fifo: synchronous show-ahead FIFO with count and full/empty.
  - Parameters WIDTH and DEPTH.
  - Implemented as a register array; no vendor RAM required.

Test Plan:
- Reset, hold joystick[0]=0x10, pulse vblank → one event: player 0, pressed=0x10, released=0, timestamp = value at the latch clock; rd_valid high 3 clocks after vblank sampled.
- Frame 2: player 0 word 0x10→0x03, player 5 word 0→0x80000000 → two events in order: (0, pressed 0x03, released 0x10) then (5, pressed 0x80000000, released 0); player 5 pushed 5 cycles after player 0.
- DEPTH=16, never read, toggle bit 0 of all 6 players across 3 frames (18 events) → count=16, overflow=1, first 16 events intact; one pop then next frame accepts the push.
- Pop on the same clock as a push while full → count stays 16, overflow unchanged; rd_en on empty → count stays 0, no underflow.
- clear during SCAN with joystick=0xFF for all players → count=0, overflow=0, FSM IDLE; next frame with unchanged inputs produces no events.
- enable=0 across a vblank with changed inputs → no events, snapshot unchanged; re-enable → changes reported on the next frame. Assert reset_n mid-SCAN → all outputs 0 immediately.

Source files
------------

// File: rtl/input_event_capture_pkg.sv
// rtl/input_event_capture_pkg.sv - shared types and helpers for input_event_capture
// Purpose: FSM state enum, event record layout, player-index width helper.
// Ports: none (package).
package input_event_capture_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Player field is fixed at 3 bits so up to 8 players fit without changing the read port.
    localparam int PLAYER_W  = 3;
    localparam int EV_JOY_W  = 32;
    localparam int EV_TS_W   = 33;

    // Event record for the default configuration; field order matches the FIFO word layout.
    typedef struct packed {
        logic [PLAYER_W-1:0] player;
        logic [EV_JOY_W-1:0] pressed;
        logic [EV_JOY_W-1:0] released;
        logic [EV_TS_W-1:0]  ts;
    } event_t;

    // Width of the scan index; a single player still needs one bit.
    function automatic int pidx_w(input int players);
        return (players > 1) ? $clog2(players) : 1;
    endfunction

endpackage

// File: rtl/input_event_fifo.sv
// rtl/input_event_fifo.sv - synchronous show-ahead FIFO with occupancy count
// Purpose: register-array FIFO; head word is always visible on rd_data.
// Ports: clk, rst_n (async active-low), clear (flush, highest priority),
//        wr_en/wr_data (push), rd_en/rd_data (pop/head), count, full, empty.
module input_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = rd_en & ~empty & ~clear;
    // A pop on the same clock frees the slot, so a push into a full FIFO still lands.
    assign do_push = wr_en & (~full | do_pop) & ~clear;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/input_event_capture.sv
// rtl/input_event_capture.sv - per-frame player input diff into a timestamped event FIFO
// Purpose: on each enabled vblank rise, latch all player words, scan one player per
//          clock against the previous frame and queue press/release events.
// Ports: clk_sys, reset_n (async active-low), joystick (player 0 in LSBs), timestamp,
//        vblank, enable, clear, rd_en; rd_valid/rd_player/rd_pressed/rd_released/
//        rd_timestamp (FIFO head), count, overflow (sticky), snapshot (previous frame).
module input_event_capture
    import input_event_capture_pkg::*;
#(
    parameter int PLAYERS = 6,
    parameter int JOY_W   = 32,
    parameter int DEPTH   = 16,
    parameter int TS_W    = 33
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic [PLAYERS*JOY_W-1:0]     joystick,
    input  logic [TS_W-1:0]              timestamp,
    input  logic                         vblank,
    input  logic                         enable,
    input  logic                         clear,
    input  logic                         rd_en,
    output logic                         rd_valid,
    output logic [2:0]                   rd_player,
    output logic [JOY_W-1:0]             rd_pressed,
    output logic [JOY_W-1:0]             rd_released,
    output logic [TS_W-1:0]              rd_timestamp,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic [PLAYERS*JOY_W-1:0]     snapshot
);
    localparam int IDX_W = pidx_w(PLAYERS);
    localparam int EV_W  = PLAYER_W + 2*JOY_W + TS_W;

    logic [PLAYERS*JOY_W-1:0] joy_q;
    logic [TS_W-1:0]          ts_q;
    logic [TS_W-1:0]          ts_lat;
    logic                     vb_q;
    logic                     vb_qq;
    logic [JOY_W-1:0]         cur  [PLAYERS];
    logic [JOY_W-1:0]         prev [PLAYERS];
    logic [IDX_W-1:0]         idx;
    state_t                   state;
    state_t                   state_nxt;

    logic                     frame_edge;
    logic                     latch;
    logic                     scan_step;
    logic                     last_player;
    logic                     push;
    logic [JOY_W-1:0]         cur_w;
    logic [JOY_W-1:0]         diff;
    logic [EV_W-1:0]          push_data;
    logic [EV_W-1:0]          head;
    logic [EV_W-1:0]          head_out;
    logic                     fifo_full;
    logic                     fifo_empty;

    assign frame_edge  = vb_q & ~vb_qq & enable;
    assign last_player = (idx == IDX_W'(PLAYERS-1));
    assign cur_w       = cur[idx];
    assign diff        = cur_w ^ prev[idx];
    assign push        = scan_step & (diff != '0);
    assign push_data   = {PLAYER_W'(idx), cur_w & diff, ~cur_w & diff, ts_lat};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            joy_q <= '0;
            ts_q  <= '0;
            vb_q  <= 1'b0;
            vb_qq <= 1'b0;
        end else begin
            joy_q <= joystick;
            ts_q  <= timestamp;
            vb_q  <= vblank;
            vb_qq <= vb_q;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        scan_step = 1'b0;
        case (state)
            IDLE: begin
                if (frame_edge) begin
                    latch     = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                // Edges arriving mid-scan are dropped; the latched frame finishes first.
                scan_step = 1'b1;
                if (last_player) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
            latch     = 1'b0;
            scan_step = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < PLAYERS; p++) begin
                cur[p]  <= '0;
                prev[p] <= '0;
            end
            ts_lat   <= '0;
            idx      <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            // Re-baseline on the live inputs so held buttons do not burst out next frame.
            for (int p = 0; p < PLAYERS; p++) prev[p] <= joy_q[p*JOY_W +: JOY_W];
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            if (latch) begin
                for (int p = 0; p < PLAYERS; p++) cur[p] <= joy_q[p*JOY_W +: JOY_W];
                ts_lat <= ts_q;
                idx    <= '0;
            end
            if (scan_step) begin
                prev[idx] <= cur_w;
                idx       <= idx + IDX_W'(1);
            end
            // Full implies non-empty, so rd_en alone means a pop frees the slot.
            if (push & fifo_full & ~rd_en) overflow <= 1'b1;
        end
    end

    input_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_sys),
        .rst_n   (reset_n),
        .clear   (clear),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (rd_en),
        .rd_data (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Head fields read as zero whenever nothing is queued.
    assign rd_valid     = ~fifo_empty;
    assign head_out     = rd_valid ? head : '0;
    assign rd_player    = head_out[EV_W-1 -: PLAYER_W];
    assign rd_pressed   = head_out[2*JOY_W+TS_W-1 -: JOY_W];
    assign rd_released  = head_out[JOY_W+TS_W-1 -: JOY_W];
    assign rd_timestamp = head_out[TS_W-1:0];

    for (genvar p = 0; p < PLAYERS; p++) begin : g_snap
        assign snapshot[p*JOY_W +: JOY_W] = prev[p];
    end

endmodule
